// File: rtl/somador_serial.sv
// Bit-serial WIDTH-bit adder: one full-adder bit per clock, LSB first, start/busy/done handshake.
// Optional subtract mode (Sub port, A - B - Cin) is compiled in with `define SOMADOR_SUB_EN.
module somador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SOMADOR_SUB_EN
  input  logic             Sub,
`endif
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, sub_q, sub_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             sub_in, bit_s, bit_c;

`ifdef SOMADOR_SUB_EN
  assign sub_in = Sub;
`else
  assign sub_in = 1'b0;
`endif

  assign bit_s = a_q[0] ^ b_q[0] ^ c_q;
  assign bit_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sub_d   = sub_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction is A + ~B + ~Cin; borrow is the inverted final carry.
          a_d     = A;
          b_d     = sub_in ? ~B : B;
          c_d     = sub_in ? ~Cin : Cin;
          sub_d   = sub_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d = {bit_s, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = bit_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // c_q here is the carry into the MSB, needed for signed overflow.
          s_d     = {bit_s, res_q[WIDTH-1:1]};
          cout_d  = bit_c ^ sub_q;
          ovf_d   = c_q ^ bit_c;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: doc/somador_serial.md
# somador_serial

Bit-serial N-bit adder: accepts two operands and a carry-in on a start pulse, then adds one bit per clock, LSB first, through a single registered carry. It performs the addition counterpart to the combinational full-subtractor cells in the arithmetic library. Its single-bit datapath trades latency for area, so it is used wherever a wide ripple adder is too large. A start/busy/done handshake connects it to the control FSMs of the problem datapath.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  operation request, sampled on rising clk
- A  input  WIDTH  first operand (addend)
- B  input  WIDTH  second operand (addend)
- Cin  input  1  carry-in
- Sub  input  1  subtract mode (present only with SOMADOR_SUB_EN)
- S  output  WIDTH  result, held until next completion
- Cout  output  1  carry-out (borrow-out in subtract mode)
- Ovf  output  1  signed overflow
- busy  output  1  operation in progress
- done  output  1  one-cycle completion strobe

One clock; reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. If start=1, latch A, B and Cin into shift registers, clear the bit counter, and go to SHIFT.
- SHIFT: busy=1. Each cycle computes the full-adder bit s=a0^b0^c and c'=a0&b0 | a0&c | b0&c.
  - s shifts into the result register from the MSB side.
  - Both operand registers shift right; the carry register takes c'.
  - The counter increments.
  - After processing bit WIDTH-1, go to DONE.
  - The carry into bit WIDTH-1 is captured for overflow.
- DONE: done=1, busy=0.
  - S is loaded with the result.
  - Cout is loaded with the final carry.
  - Ovf is loaded with carry_in_msb ^ carry_out.
  - If start=1 in this cycle, accept the new operands (same action as IDLE) and go to SHIFT; otherwise go to IDLE.
- start asserted while in SHIFT is ignored; operands are not re-latched.
- A, B and Cin may change freely after the start cycle.
- Reset at any time, including mid-operation, immediately forces:
  - state IDLE
  - S=0, Cout=0, Ovf=0, busy=0, done=0
  - internal registers and counter = 0
  - The operation in progress is discarded.
- Result width is WIDTH; the carry out of the MSB goes only to Cout.

## Timing
- start sampled at edge E0. Bits 0..WIDTH-1 are processed on edges E1..EWIDTH.
- done=1 and the new S/Cout/Ovf become visible after edge EWIDTH, exactly WIDTH cycles after E0. This gives WIDTH=8 → done 8 cycles after start.
- busy=1 from after E0 until after EWIDTH (WIDTH cycles).
- done is high for exactly one cycle.
- S/Cout/Ovf update together, on the same edge that raises done, and are stable otherwise.
- Back-to-back: start held high during DONE gives a throughput of one result per WIDTH+1 cycles; there are no dead cycles beyond DONE.
- The counter wraps only through the state transition; no bit beyond WIDTH-1 is processed.

## Configuration
- SOMADOR_SUB_EN defined:
  - Sub port present, sampled with start.
  - Sub=1 computes A − B − Cin by latching ~B and using initial carry ~Cin.
  - Cout reports the borrow, i.e. the inverted final carry; Ovf is signed subtraction overflow.
  - Sub=0 behaves as pure addition.
- SOMADOR_SUB_EN undefined:
  - No Sub port; addition only.
  - Latency and handshake are identical to the defined case.

## Test plan
- Reset: assert rst_n=0 mid-SHIFT → S=0, Cout=0, Ovf=0, busy=0, done=0 immediately. After release, a start pulse runs a normal WIDTH-cycle operation.
- A=8'h3A, B=8'h25, Cin=0, start 1 cycle → done exactly 8 cycles later with S=8'h5F, Cout=0, Ovf=0.
- A=8'hFF, B=8'h01, Cin=0 → S=8'h00, Cout=1, Ovf=0. Then A=8'h7F, B=8'h00, Cin=1 → S=8'h80, Cout=0, Ovf=1.
- Back-to-back: start held high, operand pairs (8'h10, 8'h20) then (8'hF0, 8'h20) → done pulses 9 cycles apart with S=8'h30/Cout=0, then S=8'h10/Cout=1. A start pulse during SHIFT does not disturb the result.
- SOMADOR_SUB_EN: Sub=1, A=8'h05, B=8'h07, Cin=0 → S=8'hFE, Cout(borrow)=1, Ovf=0. Sub=1, A=8'h80, B=8'h01, Cin=0 → S=8'h7F, Cout=0, Ovf=1.
